// File: rtl/ysyx_24090003_wb_arbiter_pkg.sv
// Shared definitions for the GPR writeback arbiter.
//   wb_src_e      : 2-bit writeback source encoding, also used as the bit
//                   index of each requester in request/grant vectors.
//   WB_SRC_N      : number of writeback requesters.
//   STARVE_MAX_DEF: default number of lost cycles before EXU is promoted.
//   STARVE_W      : width of the starvation counter (covers 1..15).
package ysyx_24090003_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        WB_SRC_EXU = 2'd0,
        WB_SRC_LSU = 2'd1,
        WB_SRC_CSR = 2'd2
    } wb_src_e;

    localparam int WB_SRC_N       = 3;
    localparam int STARVE_MAX_DEF = 3;
    localparam int STARVE_W       = 4;

endpackage

// File: rtl/ysyx_24090003_wb_arbiter_if.sv
// Writeback bus bundle between the EXU/LSU/CSR requesters, the IDU issue
// path and the register-file write port.
//   slave  : arbiter side (takes requests and issue, drives readies,
//            pending bitmap and the register-file write port).
//   master : requester / environment side.
interface ysyx_24090003_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_exu_valid;
    logic            o_exu_ready;
    logic [4:0]      i_exu_rd;
    logic [XLEN-1:0] i_exu_data;
    logic            i_lsu_valid;
    logic            o_lsu_ready;
    logic [4:0]      i_lsu_rd;
    logic [XLEN-1:0] i_lsu_data;
    logic            i_csr_valid;
    logic            o_csr_ready;
    logic [4:0]      i_csr_rd;
    logic [XLEN-1:0] i_csr_data;
    logic            i_issue_valid;
    logic [4:0]      i_issue_rd;
    logic [31:0]     o_pending;
    logic            o_reg_wen;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_rd_wdata;

    modport slave (
        input  i_exu_valid, i_exu_rd, i_exu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  i_csr_valid, i_csr_rd, i_csr_data,
        input  i_issue_valid, i_issue_rd,
        output o_exu_ready, o_lsu_ready, o_csr_ready,
        output o_pending, o_reg_wen, o_rd_addr, o_rd_wdata
    );

    modport master (
        output i_exu_valid, i_exu_rd, i_exu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
        output i_csr_valid, i_csr_rd, i_csr_data,
        output i_issue_valid, i_issue_rd,
        input  o_exu_ready, o_lsu_ready, o_csr_ready,
        input  o_pending, o_reg_wen, o_rd_addr, o_rd_wdata
    );
endinterface

// File: rtl/ysyx_24090003_wb_prio_sel.sv
// Combinational 3-way fixed-priority select.
//   i_req     : request vector indexed by wb_src_e.
//   i_promote : when set, EXU is moved to the top (EXU > LSU > CSR);
//               otherwise LSU > CSR > EXU.
//   o_gnt     : one-hot (or zero) grant vector indexed by wb_src_e.
module ysyx_24090003_wb_prio_sel
    import ysyx_24090003_wb_arbiter_pkg::*;
(
    input  logic [WB_SRC_N-1:0] i_req,
    input  logic                i_promote,
    output logic [WB_SRC_N-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_promote && i_req[WB_SRC_EXU]) begin
            o_gnt[WB_SRC_EXU] = 1'b1;
        end else if (i_req[WB_SRC_LSU]) begin
            o_gnt[WB_SRC_LSU] = 1'b1;
        end else if (i_req[WB_SRC_CSR]) begin
            o_gnt[WB_SRC_CSR] = 1'b1;
        end else if (i_req[WB_SRC_EXU]) begin
            o_gnt[WB_SRC_EXU] = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_24090003_wb_arbiter.sv
// GPR writeback arbiter: shares the single register-file write port
// between EXU, LSU and CSR, registers the winning write (1-cycle latency)
// and keeps a per-GPR pending-write bitmap for IDU RAW stalls.
//   i_clk, i_rst : clock, synchronous active-high reset.
//   wb (slave)   : requester handshakes, IDU issue, pending bitmap and
//                  register-file write port.
module ysyx_24090003_wb_arbiter
    import ysyx_24090003_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    ysyx_24090003_wb_arbiter_if.slave      wb
);

    logic [WB_SRC_N-1:0] req;
    logic [WB_SRC_N-1:0] gnt;
    logic                promote;
    logic                any_gnt;
    logic [4:0]          sel_rd;
    logic [XLEN-1:0]     sel_data;

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wen_q, wen_d;
    logic [4:0]          addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [31:0]         pend_q, pend_d;

    // Requests are masked during reset so no ready can be raised.
    always_comb begin
        req             = '0;
        req[WB_SRC_EXU] = wb.i_exu_valid & ~i_rst;
        req[WB_SRC_LSU] = wb.i_lsu_valid & ~i_rst;
        req[WB_SRC_CSR] = wb.i_csr_valid & ~i_rst;
    end

    assign promote = (starve_q == STARVE_W'(STARVE_MAX));

    ysyx_24090003_wb_prio_sel u_prio_sel (
        .i_req     (req),
        .i_promote (promote),
        .o_gnt     (gnt)
    );

    assign wb.o_exu_ready = gnt[WB_SRC_EXU];
    assign wb.o_lsu_ready = gnt[WB_SRC_LSU];
    assign wb.o_csr_ready = gnt[WB_SRC_CSR];
    assign any_gnt        = |gnt;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        if (gnt[WB_SRC_LSU]) begin
            sel_rd   = wb.i_lsu_rd;
            sel_data = wb.i_lsu_data;
        end else if (gnt[WB_SRC_CSR]) begin
            sel_rd   = wb.i_csr_rd;
            sel_data = wb.i_csr_data;
        end else if (gnt[WB_SRC_EXU]) begin
            sel_rd   = wb.i_exu_rd;
            sel_data = wb.i_exu_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!wb.i_exu_valid || gnt[WB_SRC_EXU]) begin
            starve_d = '0;
        end else if (starve_q < STARVE_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Address/data only move on a grant so the port holds its last write.
    always_comb begin
        wen_d  = any_gnt && (sel_rd != 5'd0);
        addr_d = any_gnt ? sel_rd   : addr_q;
        data_d = any_gnt ? sel_data : data_q;
    end

    // Set is applied after clear so a newer issue to the same rd wins.
    always_comb begin
        pend_d = pend_q;
        if (any_gnt) begin
            pend_d[sel_rd] = 1'b0;
        end
        if (wb.i_issue_valid) begin
            pend_d[wb.i_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q <= '0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            pend_q   <= '0;
        end else begin
            starve_q <= starve_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
        end
    end

    assign wb.o_reg_wen  = wen_q;
    assign wb.o_rd_addr  = addr_q;
    assign wb.o_rd_wdata = data_q;
    assign wb.o_pending  = pend_q;

endmodule

// File: tb/tb_ysyx_24090003_wb_arbiter.sv
module tb_ysyx_24090003_wb_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    logic [36:0] exp_q[$];

    ysyx_24090003_wb_arbiter_if #(.XLEN(32)) wb ();

    ysyx_24090003_wb_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-port monitor: every registered write must match the oldest expected one.
    always @(negedge clk) begin
        logic [36:0] e;
        if (wb.o_reg_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         wb.o_rd_addr, wb.o_rd_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {59'd0, wb.o_rd_addr}, {59'd0, e[36:32]});
                chk("wr_data", {32'd0, wb.o_rd_wdata}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.i_exu_valid   = 1'b0;
        wb.i_lsu_valid   = 1'b0;
        wb.i_csr_valid   = 1'b0;
        wb.i_issue_valid = 1'b0;
    endtask

    task automatic rdy(input string name, input logic e, input logic l, input logic c);
        @(negedge clk);
        chk(name, {61'd0, wb.o_exu_ready, wb.o_lsu_ready, wb.o_csr_ready}, {61'd0, e, l, c});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd1; wb.i_exu_data = 32'h1;
        wb.i_lsu_valid = 1'b1; wb.i_lsu_rd = 5'd2; wb.i_lsu_data = 32'h2;
        wb.i_csr_valid = 1'b1; wb.i_csr_rd = 5'd3; wb.i_csr_data = 32'h3;
        wb.i_issue_valid = 1'b1; wb.i_issue_rd = 5'd9;

        // Reset held two cycles with every request asserted.
        for (int i = 0; i < 2; i++) begin
            nxt();
            rdy("rst_ready", 1'b0, 1'b0, 1'b0);
            chk("rst_wen", {63'd0, wb.o_reg_wen}, 64'd0);
            chk("rst_pending", {32'd0, wb.o_pending}, 64'd0);
            chk("rst_addr", {59'd0, wb.o_rd_addr}, 64'd0);
        end
        nxt();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("post_rst_wen", {63'd0, wb.o_reg_wen}, 64'd0);

        // Single EXU write.
        nxt();
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd5; wb.i_exu_data = 32'hDEADBEEF;
        rdy("exu_single", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        nxt();
        idle();
        @(negedge clk);
        chk("exu_single_wen", {63'd0, wb.o_reg_wen}, 64'd1);
        nxt();
        @(negedge clk);
        chk("hold_addr", {59'd0, wb.o_rd_addr}, 64'd5);
        chk("hold_data", {32'd0, wb.o_rd_wdata}, 64'hDEADBEEF);
        chk("idle_wen", {63'd0, wb.o_reg_wen}, 64'd0);

        // LSU vs EXU contention.
        nxt();
        wb.i_lsu_valid = 1'b1; wb.i_lsu_rd = 5'd3; wb.i_lsu_data = 32'h11;
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd4; wb.i_exu_data = 32'h22;
        rdy("cont_lsu", 1'b0, 1'b1, 1'b0);
        exp_q.push_back({5'd3, 32'h11});
        nxt();
        wb.i_lsu_valid = 1'b0;
        rdy("cont_exu", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd4, 32'h22});
        nxt();
        idle();

        // CSR beats EXU, LSU beats CSR.
        wb.i_csr_valid = 1'b1; wb.i_csr_rd = 5'd8; wb.i_csr_data = 32'h88;
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd9; wb.i_exu_data = 32'h99;
        wb.i_lsu_valid = 1'b1; wb.i_lsu_rd = 5'd6; wb.i_lsu_data = 32'h66;
        rdy("three_lsu", 1'b0, 1'b1, 1'b0);
        exp_q.push_back({5'd6, 32'h66});
        nxt();
        wb.i_lsu_valid = 1'b0;
        rdy("csr_over_exu", 1'b0, 1'b0, 1'b1);
        exp_q.push_back({5'd8, 32'h88});
        nxt();
        wb.i_csr_valid = 1'b0;
        rdy("exu_after_csr", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd9, 32'h99});
        nxt();
        idle();

        // Starvation: EXU loses three cycles then is promoted.
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd20; wb.i_exu_data = 32'hABC;
        wb.i_lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb.i_lsu_rd = 5'(10 + i); wb.i_lsu_data = 32'h100 + i;
            rdy("starve_lose", 1'b0, 1'b1, 1'b0);
            exp_q.push_back({5'(10 + i), 32'h100 + i});
            nxt();
        end
        wb.i_lsu_rd = 5'd13; wb.i_lsu_data = 32'h103;
        rdy("starve_promote", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd20, 32'hABC});
        nxt();
        // Counter cleared: a fresh EXU request loses to LSU again.
        wb.i_exu_rd = 5'd21; wb.i_exu_data = 32'hABD;
        rdy("starve_cleared", 1'b0, 1'b1, 1'b0);
        exp_q.push_back({5'd13, 32'h103});
        nxt();
        wb.i_lsu_valid = 1'b0;
        rdy("starve_exu_alone", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd21, 32'hABD});
        nxt();
        idle();

        // Scoreboard set / clear / set-wins.
        wb.i_issue_valid = 1'b1; wb.i_issue_rd = 5'd7;
        nxt();
        idle();
        @(negedge clk);
        chk("sb_set7", {32'd0, wb.o_pending}, 64'h80);
        nxt();
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd7; wb.i_exu_data = 32'h77;
        rdy("sb_clr_grant", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd7, 32'h77});
        nxt();
        idle();
        @(negedge clk);
        chk("sb_clr7", {32'd0, wb.o_pending}, 64'h0);
        nxt();
        wb.i_issue_valid = 1'b1; wb.i_issue_rd = 5'd7;
        nxt();
        wb.i_exu_valid = 1'b1; wb.i_exu_rd = 5'd7; wb.i_exu_data = 32'h78;
        rdy("sb_coinc_grant", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({5'd7, 32'h78});
        nxt();
        idle();
        wb.i_issue_valid = 1'b1; wb.i_issue_rd = 5'd0;
        @(negedge clk);
        chk("sb_set_wins", {32'd0, wb.o_pending}, 64'h80);
        nxt();
        idle();
        @(negedge clk);
        chk("sb_issue_rd0", {32'd0, wb.o_pending}, 64'h80);

        // CSR write to x0: handshake completes, no register write.
        nxt();
        wb.i_csr_valid = 1'b1; wb.i_csr_rd = 5'd0; wb.i_csr_data = 32'h55;
        rdy("csr_rd0_ready", 1'b0, 1'b0, 1'b1);
        nxt();
        idle();
        @(negedge clk);
        chk("csr_rd0_wen", {63'd0, wb.o_reg_wen}, 64'd0);
        chk("csr_rd0_pend", {63'd0, wb.o_pending[0]}, 64'd0);
        chk("csr_rd0_pend7", {32'd0, wb.o_pending}, 64'h80);

        // Reset while a grant is in flight drops the write and the bitmap.
        nxt();
        wb.i_lsu_valid = 1'b1; wb.i_lsu_rd = 5'd12; wb.i_lsu_data = 32'hC0;
        rst = 1'b1;
        rdy("rst_mid_ready", 1'b0, 1'b0, 1'b0);
        nxt();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_mid_wen", {63'd0, wb.o_reg_wen}, 64'd0);
        chk("rst_mid_pend", {32'd0, wb.o_pending}, 64'd0);

        nxt();
        nxt();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
